wb_stage: RTL and testbench

MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core. It captures the memory-stage result, selects and aligns the final value (ALU, load with sub-word extraction, PC+4, immediate), and drives the register-file write port (`rf_we`/`rf_rd`/`rf_wdata`). It also provides an optional same-cycle bypass to decode and a retired-instruction counter.

---
 rtl/wb_stage.sv | 156 +++++++++++++++
 tb/tb_wb_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipe register and RV32I writeback; bypass outputs enabled by WB_FWD_EN
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_reg_write,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [1:0]      in_addr_lo,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [XLEN-1:0] in_imm,
    input  logic            stall,
    input  logic            flush,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_err,
    output logic [XLEN-1:0] retire_count
);

    logic            valid_q, valid_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      wb_sel_q, wb_sel_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] retire_q, retire_d;

    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;
    logic [XLEN-1:0] result;
    logic            err;

    // A held or flushed MEM stage becomes a bubble; payload fields simply keep their old value.
    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wb_sel_d    = wb_sel_q;
        alu_d       = alu_q;
        load_data_d = load_data_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        pc_plus4_d  = pc_plus4_q;
        imm_d       = imm_q;
        if (!(stall || flush)) begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write;
            rd_d        = in_rd;
            wb_sel_d    = in_wb_sel;
            alu_d       = in_alu_result;
            load_data_d = in_load_data;
            addr_lo_d   = in_addr_lo;
            funct3_d    = in_funct3;
            pc_plus4_d  = in_pc_plus4;
            imm_d       = in_imm;
        end
    end

    always_comb begin
        byte_v = load_data_q[8*addr_lo_q +: 8];
        half_v = addr_lo_q[1] ? load_data_q[31:16] : load_data_q[15:0];
        case (funct3_q)
            3'b000:  load_v = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_v = {{(XLEN-16){half_v[15]}}, half_v};
            3'b100:  load_v = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_v = {{(XLEN-16){1'b0}}, half_v};
            default: load_v = load_data_q;
        endcase
    end

    always_comb begin
        err = 1'b0;
        case (funct3_q)
            3'b001, 3'b101:         err = addr_lo_q[0];
            3'b010:                 err = (addr_lo_q != 2'd0);
            3'b011, 3'b110, 3'b111: err = 1'b1;
            default:                err = 1'b0;
        endcase
        load_err = valid_q && (wb_sel_q == 2'b01) && err;
    end

    always_comb begin
        case (wb_sel_q)
            2'b00:   result = alu_q;
            2'b01:   result = load_v;
            2'b10:   result = pc_plus4_q;
            default: result = imm_q;
        endcase
    end

    assign rf_we        = valid_q && reg_write_q && (rd_q != 5'd0) && !load_err;
    assign rf_rd        = rd_q;
    assign rf_wdata     = result;
    assign retire_count = retire_q;

    // Stores and x0 writes still retire; only faulting loads do not.
    always_comb begin
        retire_d = retire_q;
        if (valid_q && !load_err) begin
            retire_d = retire_q + 1'b1;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wb_sel_q    <= 2'b00;
            alu_q       <= '0;
            load_data_q <= '0;
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
            pc_plus4_q  <= '0;
            imm_q       <= '0;
            retire_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wb_sel_q    <= wb_sel_d;
            alu_q       <= alu_d;
            load_data_q <= load_data_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            pc_plus4_q  <= pc_plus4_d;
            imm_q       <= imm_d;
            retire_q    <= retire_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized and directed bench for wb_stage against a behavioural model
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result, in_load_data;
    logic [1:0]  in_addr_lo;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc_plus4, in_imm;
    logic        stall, flush;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_err;
    logic [31:0] retire_count;

    int n_vec = 0;
    int n_bad = 0;

    // Model of the instruction currently sitting in WB.
    bit          m_valid, m_rw;
    int unsigned m_rd, m_sel, m_lo, m_f3;
    logic [31:0] m_alu, m_ld, m_pc4, m_imm, m_cnt;

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_load_data(in_load_data),
        .in_addr_lo(in_addr_lo), .in_funct3(in_funct3), .in_pc_plus4(in_pc_plus4),
        .in_imm(in_imm), .stall(stall), .flush(flush),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_err(load_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_load();
        int unsigned w, b, h;
        w = m_ld;
        b = (w >> (8 * m_lo)) % 256;
        h = (w >> (16 * (m_lo / 2))) % 65536;
        case (m_f3)
            0: return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
            1: return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
            4: return 32'(b);
            5: return 32'(h);
            default: return m_ld;
        endcase
    endfunction

    function automatic bit m_illegal();
        return (m_f3 == 3) || (m_f3 == 6) || (m_f3 == 7);
    endfunction

    function automatic bit m_err();
        bit e;
        e = m_illegal() || ((m_f3 == 1 || m_f3 == 5) && (m_lo % 2 == 1)) || (m_f3 == 2 && m_lo != 0);
        return m_valid && (m_sel == 1) && e;
    endfunction

    function automatic logic [31:0] m_result();
        case (m_sel)
            0: return m_alu;
            1: return m_load();
            2: return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_lo = 0; m_f3 = 0;
        m_alu = 0; m_ld = 0; m_pc4 = 0; m_imm = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (m_valid && !m_err()) m_cnt = m_cnt + 1;
        if (stall || flush) begin
            m_valid = 0;
        end else begin
            m_valid = in_valid; m_rw = in_reg_write; m_rd = in_rd; m_sel = in_wb_sel;
            m_lo = in_addr_lo; m_f3 = in_funct3; m_alu = in_alu_result; m_ld = in_load_data;
            m_pc4 = in_pc_plus4; m_imm = in_imm;
        end
    endtask

    task automatic check_outputs();
        bit          e_err, e_we;
        logic [31:0] e_wd;
        e_err = m_err();
        e_we  = m_valid && m_rw && (m_rd != 0) && !e_err;
        e_wd  = m_result();
        check_eq("rf_we", 32'(rf_we), 32'(e_we));
        check_eq("rf_rd", 32'(rf_rd), 32'(m_rd));
        if (!(m_sel == 1 && m_illegal())) check_eq("rf_wdata", rf_wdata, e_wd);
        check_eq("load_err", 32'(load_err), 32'(e_err));
        check_eq("retire_count", retire_count, m_cnt);
`ifdef WB_FWD_EN
        check_eq("fwd_valid", 32'(fwd_valid), 32'(e_we));
        check_eq("fwd_rd", 32'(fwd_rd), 32'(m_rd));
        if (!(m_sel == 1 && m_illegal())) check_eq("fwd_data", fwd_data, e_wd);
`else
        check_eq("fwd_valid", 32'(fwd_valid), 32'd0);
        check_eq("fwd_rd", 32'(fwd_rd), 32'd0);
        check_eq("fwd_data", fwd_data, 32'd0);
`endif
    endtask

    // Called with clk low: drive, take one rising edge, then check at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] lo,
                         input logic [2:0] f3, input bit st, input bit fl);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
        in_alu_result = alu; in_load_data = ld; in_addr_lo = lo; in_funct3 = f3;
        in_pc_plus4 = 32'h0000_1004; in_imm = 32'hABCD_E000;
        stall = st; flush = fl;
        step();
    endtask

    task automatic bubble();
        apply(0, 0, 5'd0, 2'b00, 32'd0, 32'd0, 2'd0, 3'd0, 0, 0);
    endtask

    localparam logic [31:0] LDW = 32'h80FF7F01;

    initial begin
        reset = 1'b1;
        in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0; in_alu_result = 0;
        in_load_data = 0; in_addr_lo = 0; in_funct3 = 0; in_pc_plus4 = 0; in_imm = 0;
        stall = 0; flush = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_rf_we", 32'(rf_we), 32'd0);
        check_eq("reset_rf_wdata", rf_wdata, 32'd0);
        check_eq("reset_retire", retire_count, 32'd0);
        check_outputs();
        reset = 1'b0;

        apply(1, 1, 5'd5, 2'b00, 32'h12345678, 32'd0, 2'd0, 3'd0, 0, 0);
        check_eq("alu_we", 32'(rf_we), 32'd1);
        check_eq("alu_rd", 32'(rf_rd), 32'd5);
        check_eq("alu_wdata", rf_wdata, 32'h12345678);
        check_eq("alu_cnt_before", retire_count, 32'd0);
        bubble();
        check_eq("alu_cnt_after", retire_count, 32'd1);

        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd3, 3'b000, 0, 0);
        check_eq("lb3", rf_wdata, 32'hFFFFFF80);
        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd3, 3'b100, 0, 0);
        check_eq("lbu3", rf_wdata, 32'h00000080);
        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd2, 3'b001, 0, 0);
        check_eq("lh2", rf_wdata, 32'hFFFF80FF);
        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd0, 3'b101, 0, 0);
        check_eq("lhu0", rf_wdata, 32'h00007F01);
        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd0, 3'b010, 0, 0);
        check_eq("lw0", rf_wdata, 32'h80FF7F01);

        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd2, 3'b010, 0, 0);
        check_eq("lw2_err", 32'(load_err), 32'd1);
        check_eq("lw2_we", 32'(rf_we), 32'd0);
        apply(1, 1, 5'd7, 2'b01, 32'd0, LDW, 2'd0, 3'b011, 0, 0);
        check_eq("f3_011_err", 32'(load_err), 32'd1);
        check_eq("f3_011_we", 32'(rf_we), 32'd0);

        apply(1, 1, 5'd0, 2'b00, 32'hDEADBEEF, 32'd0, 2'd0, 3'd0, 0, 0);
        check_eq("x0_we", 32'(rf_we), 32'd0);
        apply(1, 0, 5'd4, 2'b00, 32'h00000040, 32'd0, 2'd0, 3'd2, 0, 0);
        check_eq("store_we", 32'(rf_we), 32'd0);
        bubble();

        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 5'd9, 2'b10, 32'd0, 32'd0, 2'd0, 3'd0, 1, 0);
            check_eq("stall_we", 32'(rf_we), 32'd0);
        end
        apply(1, 1, 5'd9, 2'b10, 32'd0, 32'd0, 2'd0, 3'd0, 0, 0);
        check_eq("stall_release_we", 32'(rf_we), 32'd1);
        check_eq("stall_release_pc4", rf_wdata, 32'h00001004);
        bubble();
        check_eq("stall_no_dup", 32'(rf_we), 32'd0);
        apply(1, 1, 5'd10, 2'b11, 32'd0, 32'd0, 2'd0, 3'd0, 0, 1);
        check_eq("flush_we", 32'(rf_we), 32'd0);
        apply(1, 1, 5'd11, 2'b11, 32'd0, 32'd0, 2'd0, 3'd0, 1, 1);
        check_eq("stall_flush_we", 32'(rf_we), 32'd0);

        for (int i = 0; i < 600; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_reg_write  = ($urandom_range(0, 3) != 0);
            in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_wb_sel     = 2'($urandom_range(0, 3));
            in_alu_result = $urandom;
            in_load_data  = $urandom;
            in_addr_lo    = 2'($urandom_range(0, 3));
            in_funct3     = 3'($urandom_range(0, 7));
            in_pc_plus4   = $urandom;
            in_imm        = $urandom;
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            step();
        end

        apply(1, 1, 5'd3, 2'b00, 32'h0BAD_F00D, 32'd0, 2'd0, 3'd0, 0, 0);
        check_eq("pre_reset_we", 32'(rf_we), 32'd1);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_eq("async_reset_we", 32'(rf_we), 32'd0);
        check_eq("async_reset_cnt", retire_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        bubble();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
